// File: rtl/memory_cell_arbiter_pkg.sv
// Shared definitions for the activation-memory arbiter: port select codes,
// the per-requester read tag layout and the legal address limit.
package memory_cell_arbiter_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  // One tag per requester, captured on a granted read and consumed next cycle.
  typedef struct packed {
    logic      valid;
    port_sel_e port_sel;
    logic      oor;
  } rd_tag_t;

  function automatic int unsigned mem_limit(input int unsigned num, input int unsigned timestep);
    return num * timestep;
  endfunction

  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned limit);
    return addr >= limit;
  endfunction

endpackage

// File: rtl/memory_cell_arbiter_if.sv
// Requester, return-path and memory-side signals of the arbiter.
// The slave modport is the arbiter; master is its environment.
interface memory_cell_arbiter_if #(
  parameter int ADDR  = 12,
  parameter int WIDTH = 32
);
  logic             req0, req1;
  logic             we0, we1;
  logic [ADDR-1:0]  addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1;
  logic             rvalid0, rvalid1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             err;
  logic             wr_a;
  logic [ADDR-1:0]  addr_a, addr_b;
  logic [WIDTH-1:0] i_a, o_a, o_b;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, o_a, o_b,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err,
           wr_a, addr_a, i_a, addr_b
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, o_a, o_b,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err,
           wr_a, addr_a, i_a, addr_b
  );
endinterface

// File: rtl/memory_cell_arbiter_route.sv
// Combinational routing (the mc_route block): decides grants and port
// selection for both requesters from the requests and the round-robin pointer.
module memory_cell_arbiter_route
  import memory_cell_arbiter_pkg::*;
#(
  parameter int          ADDR  = 12,
  parameter int unsigned LIMIT = 2809
) (
  input  logic            req0,
  input  logic            we0,
  input  logic [ADDR-1:0] addr0,
  input  logic            req1,
  input  logic            we1,
  input  logic [ADDR-1:0] addr1,
  input  logic            rr,
  output logic            gnt0,
  output logic            gnt1,
  output port_sel_e       sel0,
  output port_sel_e       sel1,
  output logic            oor0,
  output logic            oor1,
  output logic            ww_conflict
);

  logic act0, act1;

  // Out-of-range requests are consumed at once and never compete for a port.
  always_comb begin
    oor0        = addr_oor(32'(addr0), LIMIT);
    oor1        = addr_oor(32'(addr1), LIMIT);
    act0        = req0 && !oor0;
    act1        = req1 && !oor1;
    gnt0        = req0 && oor0;
    gnt1        = req1 && oor1;
    sel0        = PORT_A;
    sel1        = PORT_A;
    ww_conflict = 1'b0;

    if (act0 && act1) begin
      if (we0 && we1) begin
        ww_conflict = 1'b1;
        gnt0        = !rr;
        gnt1        = rr;
      end else if (!we0 && !we1) begin
        gnt0 = 1'b1;
        gnt1 = 1'b1;
        sel1 = PORT_B;
      end else if (we0) begin
        // Read of the address being written this cycle waits one cycle.
        gnt0 = 1'b1;
        gnt1 = (addr0 != addr1);
        sel1 = PORT_B;
      end else begin
        gnt1 = 1'b1;
        gnt0 = (addr0 != addr1);
        sel0 = PORT_B;
      end
    end else begin
      if (act0) gnt0 = 1'b1;
      if (act1) gnt1 = 1'b1;
    end
  end

endmodule

// File: rtl/memory_cell_arbiter.sv
// Arbitrates the forward-pass and backprop requesters onto a dual-port
// activation memory (A read/write, B read-only) and returns tagged read data.
module memory_cell_arbiter
  import memory_cell_arbiter_pkg::*;
#(
  parameter int ADDR     = 12,
  parameter int WIDTH    = 32,
  parameter int NUM      = 53*53,
  parameter int TIMESTEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_cell_arbiter_if.slave bus
);

  localparam int unsigned LIMIT = mem_limit(NUM, TIMESTEP);

  logic             gnt0_raw, gnt1_raw;
  logic             g0, g1;
  logic             oor0, oor1;
  logic             ww_conflict;
  port_sel_e        sel0, sel1;
  rd_tag_t          tag0_d, tag0_q, tag1_d, tag1_q;
  logic             rr_d, rr_q;
  logic             err_d, err_q;
  logic             v0, v1;
  logic [WIDTH-1:0] rdata0, rdata1;

  memory_cell_arbiter_route #(
    .ADDR  (ADDR),
    .LIMIT (LIMIT)
  ) u_route (
    .req0        (bus.req0),
    .we0         (bus.we0),
    .addr0       (bus.addr0),
    .req1        (bus.req1),
    .we1         (bus.we1),
    .addr1       (bus.addr1),
    .rr          (rr_q),
    .gnt0        (gnt0_raw),
    .gnt1        (gnt1_raw),
    .sel0        (sel0),
    .sel1        (sel1),
    .oor0        (oor0),
    .oor1        (oor1),
    .ww_conflict (ww_conflict)
  );

  // Grants are blocked during reset so the memory never sees a write then.
  always_comb begin
    g0          = gnt0_raw && !rst;
    g1          = gnt1_raw && !rst;
    bus.gnt0    = g0;
    bus.gnt1    = g1;
    bus.wr_a    = 1'b0;
    bus.addr_a  = '0;
    bus.i_a     = '0;
    bus.addr_b  = '0;

    if (g0 && !oor0 && sel0 == PORT_A) begin
      bus.wr_a   = bus.we0;
      bus.addr_a = bus.addr0;
      bus.i_a    = bus.we0 ? bus.wdata0 : '0;
    end else if (g1 && !oor1 && sel1 == PORT_A) begin
      bus.wr_a   = bus.we1;
      bus.addr_a = bus.addr1;
      bus.i_a    = bus.we1 ? bus.wdata1 : '0;
    end

    if (g0 && !oor0 && sel0 == PORT_B) begin
      bus.addr_b = bus.addr0;
    end else if (g1 && !oor1 && sel1 == PORT_B) begin
      bus.addr_b = bus.addr1;
    end
  end

  // After a write-write conflict the pointer moves to the loser.
  always_comb begin
    tag0_d = '{valid: g0 && !bus.we0, port_sel: sel0, oor: oor0};
    tag1_d = '{valid: g1 && !bus.we1, port_sel: sel1, oor: oor1};
    rr_d   = ww_conflict ? !rr_q : rr_q;
    err_d  = err_q || (g0 && oor0) || (g1 && oor1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag0_q <= '0;
      tag1_q <= '0;
      rr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      tag0_q <= tag0_d;
      tag1_q <= tag1_d;
      rr_q   <= rr_d;
      err_q  <= err_d;
    end
  end

  // Reset also hides a tag captured on the cycle just before it.
  always_comb begin
    v0     = tag0_q.valid && !rst;
    v1     = tag1_q.valid && !rst;
    rdata0 = '0;
    rdata1 = '0;
    if (v0 && !tag0_q.oor) rdata0 = (tag0_q.port_sel == PORT_A) ? bus.o_a : bus.o_b;
    if (v1 && !tag1_q.oor) rdata1 = (tag1_q.port_sel == PORT_A) ? bus.o_a : bus.o_b;
    bus.rvalid0 = v0;
    bus.rvalid1 = v1;
    bus.rdata0  = rdata0;
    bus.rdata1  = rdata1;
    bus.err     = err_q;
  end

endmodule

// File: tb/tb_memory_cell_arbiter.sv
// Directed scoreboard bench for memory_cell_arbiter with a behavioural
// dual-port memory (registered, read-before-write) attached.
module tb_memory_cell_arbiter;

  localparam logic [11:0] LIMIT = 12'd2809;

  typedef struct {
    logic        valid;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;
  logic exp_err = 1'b0;

  logic [31:0] mem     [4096] = '{default: 32'h0};
  logic [31:0] ref_mem [4096] = '{default: 32'h0};
  exp_t q0[$];
  exp_t q1[$];

  memory_cell_arbiter_if #(.ADDR(12), .WIDTH(32)) bus ();

  memory_cell_arbiter #(
    .ADDR     (12),
    .WIDTH    (32),
    .NUM      (53*53),
    .TIMESTEP (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.wr_a) mem[bus.addr_a] <= bus.i_a;
    bus.o_a <= mem[bus.addr_a];
    bus.o_b <= mem[bus.addr_b];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL s%0d.%s: got 0x%08h, expected 0x%08h", step, tag, got, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic r_rst,
    input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [11:0] a1, input logic [31:0] d1,
    input logic eg0, input logic eg1, input logic ewr,
    input logic [11:0] eaa, input logic [11:0] eab
  );
    exp_t        e0, e1;
    logic [31:0] exp_ia;
    step++;
    rst        = r_rst;
    bus.req0   = r0;  bus.we0 = w0;  bus.addr0 = a0;  bus.wdata0 = d0;
    bus.req1   = r1;  bus.we1 = w1;  bus.addr1 = a1;  bus.wdata1 = d1;
    #2;
    exp_ia = ewr ? ((eg0 && w0 && a0 < LIMIT) ? d0 : d1) : 32'h0;
    checkOutput("gnt0",   32'(bus.gnt0),   32'(eg0));
    checkOutput("gnt1",   32'(bus.gnt1),   32'(eg1));
    checkOutput("wr_a",   32'(bus.wr_a),   32'(ewr));
    checkOutput("addr_a", 32'(bus.addr_a), 32'(eaa));
    checkOutput("addr_b", 32'(bus.addr_b), 32'(eab));
    checkOutput("i_a",    bus.i_a,         exp_ia);

    e0 = q0.pop_front();
    e1 = q1.pop_front();
    if (r_rst) begin
      e0.valid = 1'b0;
      e1.valid = 1'b0;
    end
    checkOutput("rvalid0", 32'(bus.rvalid0), 32'(e0.valid));
    checkOutput("rdata0",  bus.rdata0,       e0.valid ? e0.data : 32'h0);
    checkOutput("rvalid1", 32'(bus.rvalid1), 32'(e1.valid));
    checkOutput("rdata1",  bus.rdata1,       e1.valid ? e1.data : 32'h0);
    if (!r_rst) checkOutput("err", 32'(bus.err), 32'(exp_err));

    if (r_rst) begin
      q0.push_back('{valid: 1'b0, data: 32'h0});
      q1.push_back('{valid: 1'b0, data: 32'h0});
      exp_err = 1'b0;
    end else begin
      q0.push_back('{valid: eg0 && !w0, data: (a0 < LIMIT) ? ref_mem[a0] : 32'h0});
      q1.push_back('{valid: eg1 && !w1, data: (a1 < LIMIT) ? ref_mem[a1] : 32'h0});
      if (eg0 && w0 && a0 < LIMIT) ref_mem[a0] = d0;
      if (eg1 && w1 && a1 < LIMIT) ref_mem[a1] = d1;
      if ((eg0 && a0 >= LIMIT) || (eg1 && a1 >= LIMIT)) exp_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    q0.push_back('{valid: 1'b0, data: 32'h0});
    q1.push_back('{valid: 1'b0, data: 32'h0});
    @(posedge clk);
    #1;

    // rst  r0 w0 a0    d0            r1 w1 a1    d1            g0 g1 wr addr_a addr_b
    applyStimulus(1, 1, 1, 12'd5,    32'h1,        0, 0, 12'd0,  32'h0,        0, 0, 0, 12'd0,  12'd0);
    applyStimulus(1, 0, 0, 12'd0,    32'h0,        0, 0, 12'd0,  32'h0,        0, 0, 0, 12'd0,  12'd0);
    applyStimulus(0, 1, 1, 12'd5,    32'h1234,     0, 0, 12'd0,  32'h0,        1, 0, 1, 12'd5,  12'd0);
    applyStimulus(0, 1, 0, 12'd5,    32'h0,        0, 0, 12'd0,  32'h0,        1, 0, 0, 12'd5,  12'd0);
    applyStimulus(0, 1, 1, 12'd7,    32'h7777,     0, 0, 12'd0,  32'h0,        1, 0, 1, 12'd7,  12'd0);
    applyStimulus(0, 1, 0, 12'd5,    32'h0,        1, 0, 12'd7,  32'h0,        1, 1, 0, 12'd5,  12'd7);
    applyStimulus(0, 1, 0, 12'd7,    32'h0,        1, 1, 12'd40, 32'h5555,     1, 1, 1, 12'd40, 12'd7);
    applyStimulus(0, 1, 0, 12'd2808, 32'h0,        0, 0, 12'd0,  32'h0,        1, 0, 0, 12'd2808, 12'd0);
    applyStimulus(0, 0, 0, 12'd0,    32'h0,        1, 0, 12'd2809, 32'h0,      0, 1, 0, 12'd0,  12'd0);
    applyStimulus(0, 0, 0, 12'd0,    32'h0,        0, 0, 12'd0,  32'h0,        0, 0, 0, 12'd0,  12'd0);
    applyStimulus(0, 1, 1, 12'd3000, 32'hDEAD,     1, 1, 12'd41, 32'h4141,     1, 1, 1, 12'd41, 12'd0);
    applyStimulus(1, 0, 0, 12'd0,    32'h0,        0, 0, 12'd0,  32'h0,        0, 0, 0, 12'd0,  12'd0);
    applyStimulus(0, 1, 1, 12'd20,   32'hA0,       1, 1, 12'd30, 32'hB0,       1, 0, 1, 12'd20, 12'd0);
    applyStimulus(0, 1, 1, 12'd21,   32'hA1,       1, 1, 12'd30, 32'hB0,       0, 1, 1, 12'd30, 12'd0);
    applyStimulus(0, 1, 1, 12'd21,   32'hA1,       1, 1, 12'd31, 32'hB1,       1, 0, 1, 12'd21, 12'd0);
    applyStimulus(0, 1, 1, 12'd22,   32'hA2,       1, 1, 12'd31, 32'hB1,       0, 1, 1, 12'd31, 12'd0);
    applyStimulus(0, 1, 0, 12'd21,   32'h0,        1, 0, 12'd30, 32'h0,        1, 1, 0, 12'd21, 12'd30);
    applyStimulus(0, 1, 1, 12'd9,    32'hBEEF,     1, 0, 12'd9,  32'h0,        1, 0, 1, 12'd9,  12'd0);
    applyStimulus(0, 0, 0, 12'd0,    32'h0,        1, 0, 12'd9,  32'h0,        0, 1, 0, 12'd9,  12'd0);
    applyStimulus(0, 1, 0, 12'd41,   32'h0,        0, 0, 12'd0,  32'h0,        1, 0, 0, 12'd41, 12'd0);
    applyStimulus(0, 1, 0, 12'd40,   32'h0,        0, 0, 12'd0,  32'h0,        1, 0, 0, 12'd40, 12'd0);
    applyStimulus(1, 0, 0, 12'd0,    32'h0,        0, 0, 12'd0,  32'h0,        0, 0, 0, 12'd0,  12'd0);
    applyStimulus(0, 0, 0, 12'd0,    32'h0,        0, 0, 12'd0,  32'h0,        0, 0, 0, 12'd0,  12'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_cell_arbiter.md
# memory_cell_arbiter

Arbitrates two requesters, the forward-pass writer/reader (R0) and the backprop reader/writer (R1), onto the shared dual-port activation memory. Port A is read/write and port B is read-only; both have 1-cycle registered read latency and return pre-write data. The block routes each request to a port, resolves write conflicts round-robin, and stalls reads that would hit a same-cycle write. It returns read data tagged per requester and flags out-of-range addresses.

## Interface
Parameters:
- ADDR, 12, address width
- WIDTH, 32, data width
- NUM, 53*53, words per timestep
- TIMESTEP, 1, timesteps stored; legal addresses are 0 .. NUM*TIMESTEP-1

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  request valid, R0 / R1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR  request address
- wdata0 / wdata1  in  WIDTH  write data
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid (registered)
- rdata0 / rdata1  out  WIDTH  read data
- err  out  1  sticky out-of-range flag
- wr_a  out  1  memory port A write enable
- addr_a  out  ADDR  memory port A address
- i_a  out  WIDTH  memory port A write data
- addr_b  out  ADDR  memory port B address
- o_a / o_b  in  WIDTH  memory read data, ports A / B

## Operation
- Handshake: reqN, weN, addrN and wdataN are held stable until gntN=1. A transfer occurs on a cycle where reqN && gntN. Requesters never retract a request before it is granted.
- Routing for a single active request: a write goes to A; a read goes to A.
- Routing for two active requests:
  - read + read: R0 goes to A, R1 goes to B, and both are granted.
  - write + read: the write goes to A and the read goes to B, and both are granted. If the addresses are equal, the read is not granted this cycle (RAW hazard stall). It retries next cycle and then returns the new data.
  - write + write: only port A can write. The winner is chosen by the round-robin pointer `rr`, where 0 favours R0. The loser is held. After a write-write conflict, `rr` points to the loser. `rr` does not change otherwise.
- Range check: if addrN >= NUM*TIMESTEP, the request is still granted (consumed), but nothing is driven to memory for it. `err` sets to 1 and stays set until `rst`. A read of this kind returns rvalidN=1 with rdataN=0.
- Idle ports: when a port is unused, the block drives wr_a=0, addr_a=0, i_a=0, addr_b=0.
- Return path: a per-requester registered tag {valid, port_sel, oor} captures each granted read. In the next cycle:
  - rvalidN equals the tag's valid bit.
  - rdataN is o_a or o_b as selected by port_sel, or 0 if oor is set.
  - When rvalidN=0, rdataN is don't-care. It is driven as 0.

## Timing
- Grant latency is 0 cycles: gnt is combinational on req and rr.
- Memory outputs (wr_a, addr_a, i_a, addr_b) are combinational and valid in the grant cycle.
- Read data latency is 1 cycle: rvalidN is asserted the cycle after the grant.
- Throughput: each requester can complete 1 access per cycle. The only exceptions are write-write conflicts and RAW stalls.
- Reset values: rr=0, rvalid0=rvalid1=0, rdata0=rdata1=0, err=0.
- While rst=1:
  - gnt0=gnt1=0 and wr_a=0, so no memory writes happen.
  - Tags clear, so an in-flight read issued in the cycle before `rst` produces no rvalid.
- Back-to-back: a write to X by R0 at cycle t followed by a read of X by R1 at t+1 returns the new data at t+2.

## Structure
- A shared header `memory_cell_defs.vh` holds:
  - `PORT_A`/`PORT_B` select encodings
  - the tag field layout
  - the limit expression NUM*TIMESTEP
- There is one combinational sub-module, `mc_route`. Its inputs are req/we/addr for both requesters plus rr. Its outputs are gnt0, gnt1, port_sel0, port_sel1, and the conflict/stall flags.
- The top level holds rr, the tags, err, and the output muxing. The top level does not instantiate memory_cell; the parent does.

## Test plan
- Reset then single ops: R0 writes 0x1234 to addr 5, then reads addr 5 → gnt0=1 on both cycles. rvalid0=1 one cycle after the read with rdata0=0x1234. err=0.
- Dual read: R0 reads 5 and R1 reads 7 in the same cycle → both granted, addr_a=5, addr_b=7. Next cycle rvalid0=rvalid1=1 with the correct data.
- Write-write round-robin: both requesters write continuously for 4 cycles after reset → grant order R0, R1, R0, R1, and wr_a=1 every cycle.
- RAW stall: R0 writes 0xBEEF to 9 while R1 reads 9 → gnt1=0 in cycle t and gnt1=1 at t+1. rdata1=0xBEEF at t+2.
- Out of range (NUM=2809, TIMESTEP=1): R1 reads 2809 → granted, wr_a=0, rvalid1=1 with rdata1=0 the next cycle. err=1 stays set until `rst`.
- Reset mid-operation: assert `rst` in the cycle after a granted read → no rvalid appears and all outputs return to their reset values.
